aes_key_expand: RTL and testbench

AES_KEY_EXPAND -- requirements
Module: aes_key_expand

---
 rtl/aes_pkg.sv | 25 ++
 rtl/aes_box.sv | 30 +++
 rtl/aes_key_expand.sv | 87 ++++++++
 tb/tb_aes_key_expand.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants: round count, round constants and FSM state encoding.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

    localparam logic [1:10][7:0] RCON = {
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Indices outside 1..10 return zero so the lookup is total.
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] r;
        r = '0;
        if (round >= 4'd1 && round <= 4'(NUM_ROUNDS)) begin
            r = RCON[round];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_box.sv
// AES forward S-box: purely combinational byte substitution.
module aes_box (
    input  logic [7:0] value,
    output logic [7:0] result
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_comb begin
        result = SBOX[value];
    end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion: emits round keys 0..10 one per accepted handshake.
module aes_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_idx,
    output logic [127:0] round_key,
    output logic         done
);

    state_t       state;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot, sub, t;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [3:0]   next_idx;
    logic         last_round;
    logic         handshake;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];

    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_box u_box (
            .value  (rot[8*i +: 8]),
            .result (sub[8*i +: 8])
        );
    end

    always_comb begin
        next_idx   = rk_idx + 4'd1;
        last_round = (rk_idx == 4'(NUM_ROUNDS));
        t   = sub ^ {rcon(next_idx), 24'h0};
        nw0 = w0 ^ t;
        nw1 = w1 ^ nw0;
        nw2 = w2 ^ nw1;
        nw3 = w3 ^ nw2;
    end

    assign busy      = (state == RUN);
    assign rk_valid  = (state == RUN);
    assign handshake = rk_valid && rk_ready;

    // done is cleared by default so it only ever lasts the single cycle after round 10.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            round_key <= '0;
            rk_idx    <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        round_key <= key_in;
                        rk_idx    <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        if (last_round) begin
                            state  <= IDLE;
                            rk_idx <= '0;
                            done   <= 1'b1;
                        end else begin
                            round_key <= {nw0, nw1, nw2, nw3};
                            rk_idx    <= next_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand using FIPS-197 and all-zero key schedules.
module tb_aes_key_expand;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready = 1'b1;
    logic [3:0]   rk_idx;
    logic [127:0] round_key;
    logic         done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t exp_q[$];
    int   done_pending = 0;

    logic [127:0] fips_tab [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    logic [127:0] zero_tab [11] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_idx    (rk_idx),
        .round_key (round_key),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue start with a key and queue the full expected sequence plus its done pulse.
    task automatic issue(input bit zero_key);
        exp_t e;
        start  = 1'b1;
        key_in = zero_key ? zero_tab[0] : fips_tab[0];
        for (int i = 0; i < 11; i++) begin
            e.idx = 4'(i);
            e.key = zero_key ? zero_tab[i] : fips_tab[i];
            exp_q.push_back(e);
        end
        done_pending++;
    endtask

    // act: 0 none, 1 stray start at trig, 2 reset at trig, 3 zero-key start in done cycle
    task automatic run(input int budget, input bit rnd, input int trig, input int act, output int cyc);
        bit fin = 1'b0;
        bit fired = 1'b0;
        cyc = 0;
        while (!fin && cyc < budget) begin
            @(posedge clk);
            cyc++;
            #1;
            start = 1'b0;
            if (cyc == 1) key_in = '1;
            if (rnd) rk_ready = 1'($urandom_range(0, 1));
            if (!fired && rk_valid && int'(rk_idx) == trig && act == 1) begin
                fired  = 1'b1;
                start  = 1'b1;
                key_in = '0;
            end
            if (!fired && rk_valid && int'(rk_idx) == trig && act == 2) begin
                fired    = 1'b1;
                rk_ready = 1'b0;
                rst      = 1'b1;
                @(posedge clk);
                #1;
                rst      = 1'b0;
                rk_ready = 1'b1;
                exp_q.delete();
                done_pending = 0;
                check("abort_busy", busy, 1'b0);
                check("abort_valid", rk_valid, 1'b0);
                check("abort_key", round_key, '0);
                check("abort_idx", rk_idx, 4'd0);
                check("abort_done", done, 1'b0);
                fin = 1'b1;
            end
            if (done) begin
                fin = 1'b1;
                if (act == 3) issue(1'b1);
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within %0d cycles", budget);
        end
    endtask

    initial begin : monitor
        exp_t         e;
        logic         stall;
        logic [127:0] held_key;
        logic [3:0]   held_idx;
        stall = 1'b0;
        held_key = '0;
        held_idx = '0;
        forever begin
            @(negedge clk);
            if (stall && rk_valid) begin
                check("stall_key", round_key, held_key);
                check("stall_idx", rk_idx, held_idx);
            end
            stall    = rk_valid && !rk_ready && !rst;
            held_key = round_key;
            held_idx = rk_idx;
            if (rk_valid === 1'b1 && rk_ready && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rk: got idx %0d with nothing expected", rk_idx);
                end else begin
                    e = exp_q.pop_front();
                    check("rk_idx", rk_idx, e.idx);
                    check("round_key", round_key, e.key);
                end
            end
            if (done === 1'b1) begin
                checks++;
                if (done_pending == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    done_pending--;
                end
            end
        end
    end

    initial begin : stimulus
        int cyc;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", rk_valid, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_idx", rk_idx, 4'd0);
        check("rst_key", round_key, '0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_valid", rk_valid, 1'b0);

        // FIPS key, ready always high: round 0 one cycle after accept, done at cycle 12
        issue(1'b0);
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = '1;
        check("r0_valid", rk_valid, 1'b1);
        check("r0_busy", busy, 1'b1);
        run(100, 1'b0, 0, 0, cyc);
        check("done_latency", cyc + 1, 12);
        check("done_not_busy", busy, 1'b0);
        check("idle_hold_key", round_key, fips_tab[10]);
        check("idle_idx", rk_idx, 4'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);

        issue(1'b1);
        run(100, 1'b0, 0, 0, cyc);

        issue(1'b0);
        run(400, 1'b1, 0, 0, cyc);
        rk_ready = 1'b1;

        issue(1'b0);
        run(100, 1'b0, 4, 1, cyc);

        issue(1'b0);
        run(100, 1'b0, 6, 2, cyc);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("post_abort_idle", rk_valid, 1'b0);
        end
        issue(1'b0);
        run(100, 1'b0, 0, 0, cyc);

        // Start issued in the done cycle must be taken immediately
        issue(1'b0);
        run(100, 1'b0, 0, 3, cyc);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_start_valid", rk_valid, 1'b1);
        check("done_start_idx", rk_idx, 4'd0);
        check("done_start_key", round_key, zero_tab[0]);
        run(100, 1'b0, 0, 0, cyc);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", 128'(exp_q.size()), '0);
        check("done_pending", 128'(done_pending), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
